// File: rtl/seven_seg_scan.sv
// Time-multiplexed, double-buffered seven-segment scan driver; one digit per enable tick.
// Optional feature: define SEG_DIM_EN to add the 4-bit PWM `brightness` input.
module seven_seg_scan #(
    parameter int DIGITS         = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  greset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
`ifdef SEG_DIM_EN
    input  logic [3:0]            brightness,
`endif
    output logic                  pending,
    output logic                  frame_done,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int SEL_W = $clog2(DIGITS);
    localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_ON    = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    // Active-low hex font, {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h40;
            4'h1: hex_seg = 7'h79;
            4'h2: hex_seg = 7'h24;
            4'h3: hex_seg = 7'h30;
            4'h4: hex_seg = 7'h19;
            4'h5: hex_seg = 7'h12;
            4'h6: hex_seg = 7'h02;
            4'h7: hex_seg = 7'h78;
            4'h8: hex_seg = 7'h00;
            4'h9: hex_seg = 7'h10;
            4'hA: hex_seg = 7'h08;
            4'hB: hex_seg = 7'h03;
            4'hC: hex_seg = 7'h46;
            4'hD: hex_seg = 7'h21;
            4'hE: hex_seg = 7'h06;
            default: hex_seg = 7'h0E;
        endcase
    endfunction

    logic [SEL_W-1:0]    digit_sel;
    logic                started;
    logic [4*DIGITS-1:0] sh_val, act_val;
    logic [DIGITS-1:0]   sh_dp, sh_blank, act_dp, act_blank;
    logic [DIGITS-1:0]   an_scan;

    logic                wrap;
    logic [SEL_W-1:0]    sel_next;
    logic [4*DIGITS-1:0] act_val_nxt;
    logic [DIGITS-1:0]   act_dp_nxt, act_blank_nxt, onehot;
    logic [3:0]          nib;
    logic                blank_d;
    logic [DIGITS-1:0]   scan_an;
    logic [6:0]          scan_seg;
    logic                scan_dp;

    // Decode looks at the post-commit buffer so digit 0 of a new frame shows fresh data
    always_comb begin
        wrap          = enable && (digit_sel == LAST_SEL);
        sel_next      = wrap ? '0 : digit_sel + SEL_W'(1);
        act_val_nxt   = act_val;
        act_dp_nxt    = act_dp;
        act_blank_nxt = act_blank;
        if (wrap && load) begin
            act_val_nxt   = value;
            act_dp_nxt    = dp_in;
            act_blank_nxt = blank_in;
        end else if (wrap && pending) begin
            act_val_nxt   = sh_val;
            act_dp_nxt    = sh_dp;
            act_blank_nxt = sh_blank;
        end
        nib      = act_val_nxt[4*int'(sel_next) +: 4];
        blank_d  = act_blank_nxt[sel_next];
        onehot   = DIGITS'(1) << sel_next;
        scan_an  = blank_d ? AN_OFF : ((AN_ACTIVE_LOW != 0) ? ~onehot : onehot);
        scan_seg = blank_d ? SEG_OFF : ((SEG_ACTIVE_LOW != 0) ? hex_seg(nib) : ~hex_seg(nib));
        scan_dp  = (act_dp_nxt[sel_next] && !blank_d) ? DP_ON : ~DP_ON;
    end

    always_ff @(posedge clock) begin
        if (greset) begin
            digit_sel  <= LAST_SEL;
            started    <= 1'b0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an_scan    <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= ~DP_ON;
        end else begin
            act_val    <= act_val_nxt;
            act_dp     <= act_dp_nxt;
            act_blank  <= act_blank_nxt;
            frame_done <= wrap && started;
            if (load) begin
                sh_val   <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank_in;
            end
            if (wrap)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
            if (enable) begin
                digit_sel <= sel_next;
                started   <= 1'b1;
                an_scan   <= scan_an;
                seg       <= scan_seg;
                dp        <= scan_dp;
            end
        end
    end

`ifdef SEG_DIM_EN
    logic [3:0] pwm_cnt;

    // Anode gated by a free-running PWM; the scan itself is untouched
    always_ff @(posedge clock) begin
        if (greset) begin
            pwm_cnt <= 4'd0;
            an      <= AN_OFF;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            an      <= (pwm_cnt >= brightness) ? AN_OFF : (enable ? scan_an : an_scan);
        end
    end
`else
    assign an = an_scan;
`endif

endmodule
